// File: rtl/decodificador_pwm_pkg.sv
// Shared types and defaults for the servo PWM encode/decode pair.
// The default period, tolerance and width thresholds live here so the
// generator and this decoder always use the same position table.
package decodificador_pwm_pkg;

  localparam int unsigned CONT_W = 32;
  localparam int unsigned POS_W  = 2;

  // Defaults for a 50 MHz clock and a 20 ms servo frame
  localparam int unsigned CONF_PERIODO_PADRAO = 1_000_000;
  localparam int unsigned TOLERANCIA_PADRAO   = 50_000;
  localparam int unsigned LIMIAR_01_PADRAO    = 62_500;
  localparam int unsigned LIMIAR_10_PADRAO    = 75_000;
  localparam int unsigned LIMIAR_11_PADRAO    = 87_500;
  localparam int unsigned TIMEOUT_PADRAO      = 2_000_000;

  typedef enum logic [1:0] {
    ESPERA = 2'b00,
    ALTO   = 2'b01,
    BAIXO  = 2'b10
  } estado_t;

  // Last accepted measurement, as presented on the outputs
  typedef struct packed {
    logic [CONT_W-1:0] largura;
    logic [CONT_W-1:0] periodo;
    logic [POS_W-1:0]  pos;
  } medida_t;

  // Counter step that sticks at all-ones instead of wrapping
  function automatic logic [CONT_W-1:0] inc_sat(input logic [CONT_W-1:0] v);
    return (v == {CONT_W{1'b1}}) ? v : v + CONT_W'(1);
  endfunction

  // Width-to-position table, inverse of the generator's encoding
  function automatic logic [POS_W-1:0] decodifica_pos(
    input logic [CONT_W-1:0] h,
    input logic [CONT_W-1:0] l01,
    input logic [CONT_W-1:0] l10,
    input logic [CONT_W-1:0] l11
  );
    if (h < l01)      return POS_W'(0);
    else if (h < l10) return POS_W'(1);
    else if (h < l11) return POS_W'(2);
    else              return POS_W'(3);
  endfunction

endpackage

// File: rtl/decodificador_pwm_sincronizador_borda.sv
// Two-flop synchronizer for the asynchronous PWM line plus a delay flop
// for edge detection. Both edges see the same 2-cycle latency.
module sincronizador_borda (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic nivel,
  output logic subida,
  output logic descida
);

  logic ff1;
  logic ff2;
  logic prev;

  // Synchronizer chain and delay flop
  always_ff @(posedge clock) begin
    if (reset) begin
      ff1  <= 1'b0;
      ff2  <= 1'b0;
      prev <= 1'b0;
    end else begin
      ff1  <= entrada;
      ff2  <= ff1;
      prev <= ff2;
    end
  end

  assign nivel   = ff2;
  assign subida  = ff2 & ~prev;
  assign descida = ~ff2 & prev;

endmodule

// File: rtl/decodificador_pwm.sv
// Servo PWM receiver: measures high time and period of pwm_in, validates
// the period against a window and decodes the width to a 2-bit position.
// Optional macro DECODIFICADOR_PWM_TIMEOUT_EN adds a stuck-line timeout
// that flags erro and returns to ESPERA.
module decodificador_pwm
  import decodificador_pwm_pkg::*;
#(
  parameter int unsigned conf_periodo = CONF_PERIODO_PADRAO,
  parameter int unsigned tolerancia   = TOLERANCIA_PADRAO,
  parameter int unsigned limiar_01    = LIMIAR_01_PADRAO,
  parameter int unsigned limiar_10    = LIMIAR_10_PADRAO,
  parameter int unsigned limiar_11    = LIMIAR_11_PADRAO
`ifdef DECODIFICADOR_PWM_TIMEOUT_EN
  ,
  parameter int unsigned timeout      = TIMEOUT_PADRAO
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [CONT_W-1:0] largura,
  output logic [CONT_W-1:0] periodo,
  output logic [POS_W-1:0]  pos,
  output logic              valido,
  output logic              erro,
  output logic [1:0]        db_estado
);

  localparam logic [CONT_W-1:0] P_MIN = CONT_W'(conf_periodo - tolerancia);
  localparam logic [CONT_W-1:0] P_MAX = CONT_W'(conf_periodo + tolerancia);
  localparam logic [CONT_W-1:0] L01   = CONT_W'(limiar_01);
  localparam logic [CONT_W-1:0] L10   = CONT_W'(limiar_10);
  localparam logic [CONT_W-1:0] L11   = CONT_W'(limiar_11);
`ifdef DECODIFICADOR_PWM_TIMEOUT_EN
  localparam logic [CONT_W-1:0] T_LIM = CONT_W'(timeout);
`endif

  logic nivel;
  logic subida;
  logic descida;

  estado_t           estado, estado_n;
  logic [CONT_W-1:0] cont_periodo, cont_periodo_n;
  logic [CONT_W-1:0] cont_alto, cont_alto_n;
  medida_t           medida, medida_n;
  logic              valido_n;
  logic              erro_n;

  sincronizador_borda u_sinc (
    .clock   (clock),
    .reset   (reset),
    .entrada (pwm_in),
    .nivel   (nivel),
    .subida  (subida),
    .descida (descida)
  );

  // State, counters and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= ESPERA;
      cont_periodo <= '0;
      cont_alto    <= '0;
      medida       <= '0;
      valido       <= 1'b0;
      erro         <= 1'b0;
    end else begin
      estado       <= estado_n;
      cont_periodo <= cont_periodo_n;
      cont_alto    <= cont_alto_n;
      medida       <= medida_n;
      valido       <= valido_n;
      erro         <= erro_n;
    end
  end

  // Next-state, counting and evaluation of a closed period at each rise
  always_comb begin
    estado_n       = estado;
    cont_periodo_n = cont_periodo;
    cont_alto_n    = cont_alto;
    medida_n       = medida;
    valido_n       = 1'b0;
    erro_n         = erro;

    unique case (estado)
      ESPERA: begin
        if (subida) begin
          estado_n       = ALTO;
          cont_periodo_n = CONT_W'(1);
          cont_alto_n    = CONT_W'(1);
        end
      end
      ALTO: begin
        cont_periodo_n = inc_sat(cont_periodo);
        if (nivel) cont_alto_n = inc_sat(cont_alto);
        if (descida) estado_n = BAIXO;
      end
      BAIXO: begin
        if (subida) begin
          if ((cont_periodo >= P_MIN) && (cont_periodo <= P_MAX)) begin
            medida_n.periodo = cont_periodo;
            medida_n.largura = cont_alto;
            medida_n.pos     = decodifica_pos(cont_alto, L01, L10, L11);
            valido_n         = 1'b1;
            erro_n           = 1'b0;
          end else begin
            erro_n = 1'b1;
          end
          estado_n       = ALTO;
          cont_periodo_n = CONT_W'(1);
          cont_alto_n    = CONT_W'(1);
        end else begin
          cont_periodo_n = inc_sat(cont_periodo);
        end
      end
      default: estado_n = ESPERA;
    endcase

`ifdef DECODIFICADOR_PWM_TIMEOUT_EN
    // Stuck line: abandon the measurement, keep the last good outputs
    if ((estado != ESPERA) && (cont_periodo >= T_LIM)) begin
      estado_n = ESPERA;
      medida_n = medida;
      valido_n = 1'b0;
      erro_n   = 1'b1;
    end
`endif
  end

  assign largura   = medida.largura;
  assign periodo   = medida.periodo;
  assign pos       = medida.pos;
  assign db_estado = estado;

endmodule

// File: tb/tb_decodificador_pwm.sv
// Scoreboard bench for decodificador_pwm with a scaled 1000-cycle frame.
module tb_decodificador_pwm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pwm_in = 1'b0;
  logic [31:0] largura;
  logic [31:0] periodo;
  logic [1:0]  pos;
  logic        valido;
  logic        erro;
  logic [1:0]  db_estado;

  always #5 clock = ~clock;

  decodificador_pwm #(
    .conf_periodo (1000),
    .tolerancia   (50),
    .limiar_01    (62),
    .limiar_10    (75),
    .limiar_11    (87)
`ifdef DECODIFICADOR_PWM_TIMEOUT_EN
    ,
    .timeout      (3000)
`endif
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .largura   (largura),
    .periodo   (periodo),
    .pos       (pos),
    .valido    (valido),
    .erro      (erro),
    .db_estado (db_estado)
  );

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] p;
    logic [1:0]  pos;
  } exp_t;

  exp_t        fila[$];
  exp_t        last_good;
  exp_t        esperado;
  exp_t        novo;
  logic        model_erro;
  bit          has_prev;
  int          prev_h;
  int          prev_p;
  logic [1:0]  prev_pos;
  bit          prev_ok;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nome, act, exp);
    end
  endtask

  // Monitor: every valido pulse must match the oldest queued expectation
  always @(negedge clock) begin
    if (valido === 1'b1) begin
      if (fila.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL valido_inesperado: got valido=1 required 0 (no pending measurement)");
      end else begin
        esperado = fila.pop_front();
        check("largura", largura, esperado.l);
        check("periodo", periodo, esperado.p);
        check("pos", 32'(pos), 32'(esperado.pos));
        check("erro_com_valido", 32'(erro), 32'd0);
      end
    end
  end

  // Rising edge that closes the previous period; checks erro and held outputs
  task automatic close_rise();
    pwm_in = 1'b1;
    if (has_prev) begin
      if (prev_ok) begin
        novo.l   = 32'(prev_h);
        novo.p   = 32'(prev_p);
        novo.pos = prev_pos;
        fila.push_back(novo);
        last_good  = novo;
        model_erro = 1'b0;
      end else begin
        model_erro = 1'b1;
      end
    end
    repeat (4) @(negedge clock);
    check("erro", 32'(erro), 32'(model_erro));
    check("largura_mantida", largura, last_good.l);
    check("periodo_mantido", periodo, last_good.p);
    check("pos_mantida", 32'(pos), 32'(last_good.pos));
  endtask

  // One PWM frame: h cycles high, p-h cycles low
  task automatic send(input int h, input int p, input logic [1:0] epos, input bit ok);
    close_rise();
    repeat (h - 4) @(negedge clock);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clock);
    prev_h   = h;
    prev_p   = p;
    prev_pos = epos;
    prev_ok  = ok;
    has_prev = 1'b1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pwm_in = 1'b0;
    @(negedge clock);
    check("rst_largura", largura, 32'd0);
    check("rst_periodo", periodo, 32'd0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_valido", 32'(valido), 32'd0);
    check("rst_erro", 32'(erro), 32'd0);
    check("rst_db_estado", 32'(db_estado), 32'd0);
    reset      = 1'b0;
    has_prev   = 1'b0;
    model_erro = 1'b0;
    last_good  = '0;
    fila.delete();
  endtask

  initial begin
    has_prev   = 1'b0;
    model_erro = 1'b0;
    last_good  = '0;
    do_reset();
    repeat (5) @(negedge clock);

    // Nominal frames, first rise produces nothing
    send(56, 1000, 2'b00, 1'b1);
    send(56, 1000, 2'b00, 1'b1);
    send(56, 1000, 2'b00, 1'b1);
    // Width sweep and threshold boundaries
    send(68, 1000, 2'b01, 1'b1);
    send(81, 1000, 2'b10, 1'b1);
    send(94, 1000, 2'b11, 1'b1);
    send(61, 1000, 2'b00, 1'b1);
    send(62, 1000, 2'b01, 1'b1);
    send(74, 1000, 2'b01, 1'b1);
    send(75, 1000, 2'b10, 1'b1);
    send(86, 1000, 2'b10, 1'b1);
    send(87, 1000, 2'b11, 1'b1);
    // Period window edges and out-of-window periods
    send(56, 950, 2'b00, 1'b1);
    send(56, 1050, 2'b00, 1'b1);
    send(70, 1100, 2'b01, 1'b0);
    send(70, 1000, 2'b01, 1'b1);
    send(56, 949, 2'b00, 1'b0);
    send(56, 1000, 2'b00, 1'b1);
    send(94, 1051, 2'b11, 1'b0);
    send(56, 1000, 2'b00, 1'b1);

    // Reset while high
    close_rise();
    repeat (10) @(negedge clock);
    check("db_estado_alto", 32'(db_estado), 32'd1);
    do_reset();
    repeat (20) @(negedge clock);

    // Generator-style position changes, two frames each
    send(80, 1000, 2'b10, 1'b1);
    send(80, 1000, 2'b10, 1'b1);
    send(50, 1000, 2'b00, 1'b1);
    send(50, 1000, 2'b00, 1'b1);
    send(95, 1000, 2'b11, 1'b1);
    send(95, 1000, 2'b11, 1'b1);
    send(65, 1000, 2'b01, 1'b1);
    send(65, 1000, 2'b01, 1'b1);

    // Stuck-high line
    close_rise();
    repeat (3096) @(negedge clock);
`ifdef DECODIFICADOR_PWM_TIMEOUT_EN
    check("stuck_erro", 32'(erro), 32'd1);
    check("stuck_db_estado", 32'(db_estado), 32'd0);
`else
    check("stuck_erro", 32'(erro), 32'd0);
    check("stuck_db_estado", 32'(db_estado), 32'd1);
`endif
    check("stuck_largura", largura, last_good.l);
    repeat (900) @(negedge clock);
`ifdef DECODIFICADOR_PWM_TIMEOUT_EN
    check("stuck_erro_4000", 32'(erro), 32'd1);
    check("stuck_db_estado_4000", 32'(db_estado), 32'd0);
`else
    check("stuck_erro_4000", 32'(erro), 32'd0);
    check("stuck_db_estado_4000", 32'(db_estado), 32'd1);
`endif
    check("stuck_pos", 32'(pos), 32'(last_good.pos));
    check("fila_vazia", 32'(fila.size()), 32'd0);
    pwm_in = 1'b0;
    do_reset();
    repeat (10) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/decodificador_pwm.md
# decodificador_pwm

Receive-side counterpart of the servo PWM generator: samples an incoming PWM waveform, measures pulse width and period in clock cycles, validates the period against a window, and decodes the width back to the 2-bit position code. It sits between an external or looped-back PWM line and the control/debug logic, and serves as a hardware checker for the generator.

## Interface
- `conf_periodo`, 1_000_000: nominal period in cycles (20 ms at 50 MHz).
- `tolerancia`, 50_000: accepted period deviation, ± cycles.
- `limiar_01`, 62_500: width threshold for pos ≥ 01.
- `limiar_10`, 75_000: width threshold for pos ≥ 10.
- `limiar_11`, 87_500: width threshold for pos = 11.
- `timeout`, 2_000_000: cycles without a rising edge before error (used only with the macro).
- `clock` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `pwm_in` in 1: asynchronous PWM input.
- `largura` out 32: last valid high time, in cycles.
- `periodo` out 32: last valid period, in cycles.
- `pos` out 2: decoded position.
- `valido` out 1: one-cycle pulse when a new valid measurement is latched.
- `erro` out 1: invalid period or timeout. Held until the next valid measurement.
- `db_estado` out 2: FSM state, for debug.

## Operation
- `pwm_in` passes through a 2-FF synchronizer into a delay FF. A rise is `sync=1 & prev=0`.
- FSM states:
  - ESPERA = 00: after reset, waits for the first rise.
  - ALTO = 01: signal is high.
  - BAIXO = 10: signal is low.
- ESPERA: falling edges and a constant level are ignored. On a rise, set `cont_periodo` and `cont_alto` to 1 and go to ALTO. No `valido` is issued for this first rise.
- ALTO: `cont_periodo` and `cont_alto` increment every cycle. On a fall, go to BAIXO.
- BAIXO: `cont_periodo` increments every cycle. On a rise:
  - Evaluate P = `cont_periodo` and H = `cont_alto`.
  - Reload both counters to 1 and go to ALTO.
- Validity rule: `conf_periodo - tolerancia` ≤ P ≤ `conf_periodo + tolerancia`.
- If valid:
  - `periodo` ← P, `largura` ← H.
  - `pos` ← 00 if H < `limiar_01`; 01 if H < `limiar_10`; 10 if H < `limiar_11`; else 11.
  - Pulse `valido`; clear `erro`.
- If invalid: set `erro`. `largura`, `periodo` and `pos` hold their previous values and `valido` stays 0.
- Both counters are 32 bits unsigned and saturate at 0xFFFF_FFFF; they never wrap.
- Reset at any time, including mid-measurement: state goes to ESPERA and the current measurement is discarded.
- Reset values: `largura`=0, `periodo`=0, `pos`=00, `valido`=0, `erro`=0, `db_estado`=00.
- Pulses shorter than 2 cycles may be lost in the synchronizer. This is accepted.

## Timing
- Input-to-detect latency is 2 cycles. Rising and falling edges are delayed equally, so a high time of H cycles measures exactly H and a period of P measures exactly P.
- `valido` is high for exactly one cycle: the cycle after the clock edge at which the closing rise is detected (3 edges after `pwm_in` is first sampled high).
- `largura`, `periodo`, `pos` and `erro` update on the same edge that raises `valido`, and are stable until the next evaluation.
- `erro` is registered, set on the same edge, and never asserted together with `valido`.
- Steady throughput: one measurement per PWM period.

## Configuration
- `DECODIFICADOR_PWM_TIMEOUT_EN` defined:
  - In ALTO or BAIXO, when `cont_periodo` reaches `timeout`, set `erro` and go to ESPERA. Outputs hold.
  - Covers a stuck-high or stuck-low line.
- Undefined: no timeout logic. A stuck line leaves the FSM in ALTO/BAIXO with saturated counters, and `erro` is raised only by the validity check at the next rise.

## Structure
- Shared package holds:
  - State encoding constants ESPERA/ALTO/BAIXO.
  - Default period, tolerance and threshold constants, shared with the generator so that encode and decode tables match.
- Sub-module `sincronizador_borda`: 2-FF synchronizer, delay FF, outputs `nivel`, `subida`, `descida`; synchronous reset to 0.

## Test plan
All scenarios use `conf_periodo`=1000, `tolerancia`=50, thresholds 62/75/87, `timeout`=3000.
- Reset, then PWM with H=56, P=1000: the first rise gives no `valido`; each later period gives `valido`, `largura`=56, `periodo`=1000, `pos`=00.
- Sweep H = 68, 81, 94 (P=1000): `pos` = 01, 10, 11. Boundary widths H=61 → 00 and H=62 → 01.
- Period P=1100 with H=70: `erro`=1, no `valido`, outputs keep previous values. A following P=1000 period clears `erro` and pulses `valido`.
- `pwm_in` stuck high for 4000 cycles:
  - With the macro: `erro`=1 and `db_estado`=00 after 3000 cycles.
  - Without it: `db_estado` stays 01 and `erro` stays 0.
- Reset asserted during ALTO: all outputs return to reset values next cycle and `db_estado`=00. The next full period is required before any `valido`.
- Loopback from the servo PWM generator output (default parameters) through 4 position changes: `pos` tracks each change within 2 periods.
